// File: rtl/sar_search_pkg.sv
// Shared types for the successive-approximation search controller.
// Holds the FSM state encoding and the comparator flag checks.
package sar_search_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PROBE  = 2'd1,
    VERIFY = 2'd2,
    DONE   = 2'd3
  } sar_state_t;

  typedef struct packed {
    logic eq;
    logic lt;
    logic gt;
  } cmp_flags_t;

  // A healthy comparator raises exactly one of eq/lt/gt.
  function automatic logic flags_one_hot(input cmp_flags_t f);
    return $onehot({f.eq, f.lt, f.gt});
  endfunction

  function automatic logic flags_exact_eq(input cmp_flags_t f);
    return f.eq && !f.lt && !f.gt;
  endfunction

endpackage

// File: rtl/sar_search_if.sv
// Connection bundle between the search controller and its environment:
// start/status towards the requester, trial/flags towards the comparator.
interface sar_search_if #(
  parameter int WIDTH = 4
);

  logic             start;
  logic [WIDTH-1:0] trial;
  logic             cmp_eq;
  logic             cmp_lt;
  logic             cmp_gt;
  logic             busy;
  logic             done;
  logic             found;
  logic             err;
  logic [WIDTH-1:0] result;

  modport master (
    input  start, cmp_eq, cmp_lt, cmp_gt,
    output trial, busy, done, found, err, result
  );

  modport slave (
    output start, cmp_eq, cmp_lt, cmp_gt,
    input  trial, busy, done, found, err, result
  );

endinterface

// File: rtl/sar_settle_timer.sv
// Loadable down-counter that paces each trial; expire is high once the
// count has run out, marking the cycle on which the flags are trusted.
module sar_settle_timer #(
  parameter int CW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_value,
  output logic          expire
);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expire = (count == '0);

endmodule

// File: rtl/sar_search.sv
// Successive-approximation controller: drives the comparator A side, binary
// searches for the unknown B operand and confirms the final value.
module sar_search
  import sar_search_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic          clk,
  input  logic          rst,
  sar_search_if.master  bus
);

  localparam int               PW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int               CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]    RELOAD   = CW'(SETTLE - 1);
  localparam logic [PW-1:0]    MSB_PTR  = PW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

  sar_state_t       state;
  logic [WIDTH-1:0] trial_r;
  logic [WIDTH-1:0] result_r;
  logic [PW-1:0]    bit_ptr;
  logic             busy_r;
  logic             done_r;
  logic             found_r;
  logic             err_r;

  cmp_flags_t       flags;
  logic             flags_valid;
  logic             exact_eq;
  logic             accept;
  logic             timer_load;
  logic             expire;
  logic [WIDTH-1:0] cur_mask;
  logic [WIDTH-1:0] next_mask;
  logic [WIDTH-1:0] working;

  // The working value drops the bit under test when the trial overshoots B.
  always_comb begin
    flags       = {bus.cmp_eq, bus.cmp_lt, bus.cmp_gt};
    flags_valid = flags_one_hot(flags);
    exact_eq    = flags_exact_eq(flags);
    cur_mask    = WIDTH'(1) << bit_ptr;
    next_mask   = cur_mask >> 1;
    working     = flags.gt ? (trial_r & ~cur_mask) : trial_r;
    accept      = bus.start && ((state == IDLE) || (state == DONE));
    timer_load  = accept || (((state == PROBE) || (state == VERIFY)) && expire);
  end

  sar_settle_timer #(
    .CW (CW)
  ) u_settle_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (timer_load),
    .load_value (RELOAD),
    .expire     (expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      trial_r  <= '0;
      result_r <= '0;
      bit_ptr  <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      found_r  <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state   <= PROBE;
            trial_r <= MSB_MASK;
            bit_ptr <= MSB_PTR;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
            found_r <= 1'b0;
            err_r   <= 1'b0;
          end
        end

        // Flags are only looked at once the settle time has elapsed.
        PROBE: begin
          if (expire) begin
            if (!flags_valid) begin
              result_r <= trial_r;
              err_r    <= 1'b1;
              busy_r   <= 1'b0;
              done_r   <= 1'b1;
              state    <= DONE;
            end else if (flags.eq) begin
              result_r <= trial_r;
              found_r  <= 1'b1;
              busy_r   <= 1'b0;
              done_r   <= 1'b1;
              state    <= DONE;
            end else if (bit_ptr != '0) begin
              trial_r <= working | next_mask;
              bit_ptr <= bit_ptr - 1'b1;
            end else begin
              trial_r <= working;
              state   <= VERIFY;
            end
          end
        end

        VERIFY: begin
          if (expire) begin
            result_r <= trial_r;
            found_r  <= exact_eq;
            err_r    <= !exact_eq;
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
            state    <= DONE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.trial  = trial_r;
  assign bus.result = result_r;
  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.found  = found_r;
  assign bus.err    = err_r;

endmodule
